// File: rtl/bus_demux4.sv
// bus_demux4: single-initiator to four-target request demux with one-cycle response
// Optional watchdog: define BUS_DEMUX4_TIMEOUT_EN to end stalled transactions with resp_err.
module bus_demux4 #(
  parameter int WIDTH          = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int SEL_LSB        = 28,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [WIDTH-1:0]      req_wdata,
  output logic                  resp_valid,
  output logic [WIDTH-1:0]      resp_rdata,
  output logic                  resp_err,
  output logic [3:0]            tgt_valid,
  output logic                  tgt_we,
  output logic [ADDR_WIDTH-1:0] tgt_addr,
  output logic [WIDTH-1:0]      tgt_wdata,
  input  logic [3:0]            tgt_ready,
  input  logic [3:0]            tgt_rvalid,
  input  logic [WIDTH-1:0]      tgt_rdata0,
  input  logic [WIDTH-1:0]      tgt_rdata1,
  input  logic [WIDTH-1:0]      tgt_rdata2,
  input  logic [WIDTH-1:0]      tgt_rdata3
);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, nxt;
  logic [1:0] sel, sel_n;
  logic acc, ack, rd_done, done, to;
  logic [WIDTH-1:0] rdata_sel;
  if (TIMEOUT_CYCLES < 1) begin : g_chk
    $error("TIMEOUT_CYCLES must be >= 1");
  end
  assign req_ready = state == IDLE;
  assign acc       = req_ready && req_valid;
  assign ack       = state == ISSUE && tgt_ready[sel];
  assign rd_done   = state == WAIT && tgt_rvalid[sel];
  assign done      = rd_done || (ack && tgt_we);
  assign sel_n     = acc ? req_addr[SEL_LSB+:2] : sel;
  assign rdata_sel = sel[1] ? (sel[0] ? tgt_rdata3 : tgt_rdata2) : (sel[0] ? tgt_rdata1 : tgt_rdata0);
`ifdef BUS_DEMUX4_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic busy;
  assign busy = state == ISSUE || state == WAIT;
  // >= so a read accepted on the limit cycle still times out from WAIT
  assign to = busy && cnt >= CW'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (acc) cnt <= '0;
    else if (busy) cnt <= cnt + 1'b1;
`else
  assign to = 1'b0;
`endif
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  nxt = acc ? ISSUE : IDLE;
      ISSUE: nxt = ack ? (tgt_we ? RESP : WAIT) : (to ? RESP : ISSUE);
      WAIT:  nxt = (rd_done || to) ? RESP : WAIT;
      RESP:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= '0;
      tgt_valid  <= '0;
      tgt_we     <= 1'b0;
      tgt_addr   <= '0;
      tgt_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state      <= nxt;
      sel        <= sel_n;
      tgt_valid  <= nxt == ISSUE ? 4'b0001 << sel_n : 4'b0000;
      if (acc) begin
        tgt_we    <= req_we;
        tgt_addr  <= req_addr;
        tgt_wdata <= req_wdata;
      end
      resp_valid <= nxt == RESP;
      resp_rdata <= rd_done ? rdata_sel : '0;
      resp_err   <= nxt == RESP && !done;
    end
endmodule

// File: doc/bus_demux4.md
# bus_demux4

Single-initiator to four-target request demultiplexer for the core's data bus. It accepts one load/store request at a time, decodes the target from two address bits, and drives that target's valid/ready handshake. It waits for the target's completion and returns a single-cycle response to the initiator. It sits between the memory stage and the data RAM / peripheral blocks (GPIO, UART, timer) and is the routing counterpart to the 4-way data-return selection.

## Interface
- `WIDTH`, 32: data width.
- `ADDR_WIDTH`, 32: address width.
- `SEL_LSB`, 28: target index is `req_addr[SEL_LSB+1:SEL_LSB]`.
- `TIMEOUT_CYCLES`, 15: watchdog limit, used only with `BUS_DEMUX4_TIMEOUT_EN`; must be ≥ 1.
- `clk`  in  1  single clock, all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  initiator request present.
- `req_ready`  out  1  block can accept; equals `state==IDLE`.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_WIDTH  request address.
- `req_wdata`  in  WIDTH  write data.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  WIDTH  read data; 0 for writes and errors.
- `resp_err`  out  1  completion was a timeout; tied 0 without the macro.
- `tgt_valid`  out  4  one-hot request to target i.
- `tgt_we`, `tgt_addr`, `tgt_wdata`  out  1 / ADDR_WIDTH / WIDTH  registered request fields, shared by all targets.
- `tgt_ready`  in  4  target i accepts.
- `tgt_rvalid`  in  4  target i read data valid.
- `tgt_rdata0..tgt_rdata3`  in  WIDTH each  per-target read data.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- **IDLE**: `req_ready`=1.
  - On `req_valid`, latch `we`, `addr` and `wdata` into the `tgt_*` registers and latch `sel`.
  - Go to ISSUE.
- **ISSUE**: `tgt_valid[sel]`=1; all other bits are 0.
  - Hold until `tgt_ready[sel]`=1.
  - On acceptance, a write goes to RESP with rdata=0.
  - On acceptance, a read goes to WAIT.
  - `tgt_ready` from non-selected targets is ignored.
- **WAIT**: `tgt_valid`=0.
  - On `tgt_rvalid[sel]`, capture `tgt_rdata<sel>` and go to RESP.
  - `tgt_rvalid` from other targets is ignored.
  - A `tgt_rvalid[sel]` asserted in the same cycle as acceptance in ISSUE is ignored; read data must arrive at least one cycle after acceptance.
- **RESP**: `resp_valid`=1 for exactly one cycle, then go to IDLE.
  - The initiator has no backpressure on responses.
- `tgt_we`, `tgt_addr` and `tgt_wdata` stay stable from ISSUE entry until the next accept.
- Only one transaction is ever outstanding.
- Reset values, including a reset mid-transaction:
  - State returns to IDLE immediately (asynchronous).
  - `tgt_valid`=0, `resp_valid`=0, `resp_rdata`=0, `resp_err`=0.
  - `tgt_we`, `tgt_addr`, `tgt_wdata` = 0; the timeout counter = 0.
  - `req_ready`=1 combinationally, but no request is latched while `rst_n`=0.
  - An in-flight transaction is dropped without a response.

## Timing
- Request accepted at edge 0 (`req_valid & req_ready`); `tgt_valid[sel]` is high during cycle 1.
- Write, target ready in cycle 1: `resp_valid` in cycle 2. Minimum write latency is 2 cycles.
- Read, ready in cycle 1, `tgt_rvalid` in cycle k ≥ 2: `resp_valid` and `resp_rdata` in cycle k+1. Minimum read latency is 3 cycles.
- `req_ready` is 0 from cycle 1 through the RESP cycle. The next accept is possible in the cycle after RESP.
- All outputs are registered except `req_ready`.

## Configuration
- Macro: `BUS_DEMUX4_TIMEOUT_EN`.
- **Defined**:
  - A counter is cleared on accept and increments on every cycle spent in ISSUE or WAIT.
  - When it reaches `TIMEOUT_CYCLES` without completion, go to RESP with `resp_err`=1, `resp_rdata`=0 and `tgt_valid` dropped.
  - If completion and timeout coincide in the same cycle, completion wins (`resp_err`=0).
- **Undefined**: no counter; ISSUE and WAIT wait indefinitely; `resp_err` is constant 0.

## Test plan
- Write `addr`=0x2000_0010, `wdata`=0xDEAD_BEEF, `tgt_ready[2]` already high → `tgt_valid`=4'b0100 in cycle 1 with `tgt_addr` and `tgt_wdata` matching; `resp_valid` in cycle 2 with rdata=0 and err=0.
- Read `addr`=0x1000_0004, `tgt_ready[1]` delayed 3 cycles, `tgt_rvalid[1]` 2 cycles later with `tgt_rdata1`=0x1234_5678 → `resp_rdata`=0x1234_5678 one cycle after rvalid; `tgt_valid` held stable during the stall.
- Read to target 3 while `tgt_ready[0]`, `tgt_rvalid[0]` and `tgt_rvalid[1]` pulse with junk data → ignored; the response carries only `tgt_rdata3`.
- Back-to-back: `req_valid` held high for two writes → second accept occurs the cycle after the first RESP; `req_ready`=0 in between.
- `rst_n` pulsed low while in WAIT → all outputs 0 immediately, no `resp_valid`; after release, a new read completes normally.
- With `BUS_DEMUX4_TIMEOUT_EN` and `TIMEOUT_CYCLES`=15, target 0 never ready → `resp_valid` with `resp_err`=1 and rdata=0 after 15 cycles in ISSUE; without the macro, no response after 100 cycles.
